// File: rtl/tile_host_dma_if.sv
// tile_host_dma_if
//   Bundles every handshake and bus signal of tile_host_dma except clk/rst.
//   Signal groups:
//     cmd_*        : host command (valid/ready, op, tile_i, tile_j)
//     in_*         : operand byte stream into the DMA (A bytes, then B bytes)
//     out_*        : result byte stream out of the DMA (with out_last)
//     sram_A/B_*   : operand SRAM write ports
//     sram_C_*     : result SRAM read port (1-cycle read latency)
//     tp_*         : tile processor control (start/op/tile indices, done)
//     busy, err    : status
//   Modports:
//     slave  : the DMA itself
//     master : the host / surrounding environment
interface tile_host_dma_if;
   // Command
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_tile_i;
   logic [2:0] cmd_tile_j;
   // Operand stream
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   // Result stream
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   // Operand SRAM write ports
   logic       sram_A_we;
   logic       sram_B_we;
   logic [9:0] sram_A_addr;
   logic [9:0] sram_B_addr;
   logic [7:0] sram_A_din;
   logic [7:0] sram_B_din;
   // Result SRAM read port
   logic [9:0] sram_C_addr;
   logic [7:0] sram_C_dout;
   // Tile processor control
   logic       tp_start;
   logic [2:0] tp_op;
   logic [2:0] tp_tile_i;
   logic [2:0] tp_tile_j;
   logic       tp_done;
   // Status
   logic       busy;
   logic       err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_tile_i, cmd_tile_j,
      output cmd_ready,
      input  in_valid, in_data,
      output in_ready,
      output out_valid, out_data, out_last,
      input  out_ready,
      output sram_A_we, sram_B_we, sram_A_addr, sram_B_addr, sram_A_din, sram_B_din,
      output sram_C_addr,
      input  sram_C_dout,
      output tp_start, tp_op, tp_tile_i, tp_tile_j,
      input  tp_done,
      output busy, err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_tile_i, cmd_tile_j,
      input  cmd_ready,
      output in_valid, in_data,
      input  in_ready,
      input  out_valid, out_data, out_last,
      output out_ready,
      input  sram_A_we, sram_B_we, sram_A_addr, sram_B_addr, sram_A_din, sram_B_din,
      input  sram_C_addr,
      output sram_C_dout,
      input  tp_start, tp_op, tp_tile_i, tp_tile_j,
      output tp_done,
      input  busy, err
   );
endinterface

// File: rtl/tile_host_dma.sv
// tile_host_dma
//   Host-side DMA for a tile processor. Accepts a command (op, tile_i, tile_j), streams the A
//   and B operand bytes into the operand SRAMs, kicks the tile processor, waits for it (with
//   a timeout), then reads the result bytes back from the result SRAM and streams them out.
//   Ports:
//     clk    : sole clock, rising edge
//     rst    : asynchronous, active-high reset
//     bus_io : tile_host_dma_if.slave (command, operand/result streams, SRAM ports,
//              tile processor control, busy/err)
//   Parameters:
//     TIMEOUT : cycles allowed in the tile-processor wait before the command is aborted
module tile_host_dma #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic           clk,
   input  logic           rst,
   tile_host_dma_if.slave bus_io
);

   localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StKick,
      StWaitTp,
      StRdIssue,
      StRdCap,
      StRdOut
   } state_e;

   // Byte counts for A, B and C of one command; 7 bits so 64 fits.
   typedef struct packed {
      logic [6:0] a;
      logic [6:0] b;
      logic [6:0] c;
   } counts_t;

   function automatic counts_t op_counts(input logic [2:0] op);
      counts_t cnt;
      case (op)
         3'd0:    cnt = '{a: 7'd64, b: 7'd64, c: 7'd16};  // MUL
         3'd1,
         3'd2:    cnt = '{a: 7'd16, b: 7'd16, c: 7'd16};  // ADD, SUB
         3'd3:    cnt = '{a: 7'd36, b: 7'd9,  c: 7'd16};  // CONV
         3'd4:    cnt = '{a: 7'd16, b: 7'd16, c: 7'd1};   // DOT
         default: cnt = '0;
      endcase
      return cnt;
   endfunction

   state_e            state_q, state_d;
   logic [6:0]        idx_q, idx_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        op_q, op_d;
   logic [2:0]        ti_q, ti_d;
   logic [2:0]        tj_q, tj_d;
   counts_t           cnt_q, cnt_d;
   counts_t           cmd_cnt;

   logic              a_we_q, a_we_d;
   logic              b_we_q, b_we_d;
   logic [9:0]        a_addr_q, a_addr_d;
   logic [9:0]        b_addr_q, b_addr_d;
   logic [7:0]        a_din_q, a_din_d;
   logic [7:0]        b_din_q, b_din_d;
   logic [9:0]        c_addr_q, c_addr_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              tp_start_q, tp_start_d;
   logic [2:0]        tp_op_q, tp_op_d;
   logic [2:0]        tp_ti_q, tp_ti_d;
   logic [2:0]        tp_tj_q, tp_tj_d;
   logic              err_q, err_d;

   logic              cmd_ready;
   logic [9:0]        a_base;
   logic [9:0]        b_base;
   logic [9:0]        c_base;

   // cmd_ready is gated by rst so it reads 0 for the whole reset, not just after the edge.
   assign cmd_ready = (state_q == StIdle) && !rst;

   assign a_base = {2'b00, ti_q, 5'b00000};
   assign c_base = a_base;
   always_comb begin
      b_base = a_base;
      if (op_q == 3'd0) begin
         b_base = '0;
      end else if (op_q == 3'd4) begin
         b_base = {3'b000, tj_q, 4'b0000};
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      op_d       = op_q;
      ti_d       = ti_q;
      tj_d       = tj_q;
      cnt_d      = cnt_q;
      a_we_d     = 1'b0;
      b_we_d     = 1'b0;
      a_addr_d   = a_addr_q;
      b_addr_d   = b_addr_q;
      a_din_d    = a_din_q;
      b_din_d    = b_din_q;
      c_addr_d   = c_addr_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      tp_start_d = 1'b0;
      tp_op_d    = tp_op_q;
      tp_ti_d    = tp_ti_q;
      tp_tj_d    = tp_tj_q;
      err_d      = 1'b0;
      cmd_cnt    = op_counts(bus_io.cmd_op);

      unique case (state_q)
         StIdle: begin
            if (bus_io.cmd_valid && cmd_ready) begin
               if (bus_io.cmd_op > 3'd4) begin
                  err_d = 1'b1;
               end else begin
                  op_d  = bus_io.cmd_op;
                  ti_d  = bus_io.cmd_tile_i;
                  tj_d  = bus_io.cmd_tile_j;
                  cnt_d = cmd_cnt;
                  idx_d = '0;
                  if (cmd_cnt.a != '0) begin
                     state_d = StLoadA;
                  end else if (cmd_cnt.b != '0) begin
                     state_d = StLoadB;
                  end else begin
                     state_d = StKick;
                  end
               end
            end
         end

         StLoadA: begin
            if (bus_io.in_valid) begin
               a_we_d   = 1'b1;
               a_addr_d = a_base + 10'(idx_q);
               a_din_d  = bus_io.in_data;
               if (idx_q == cnt_q.a - 7'd1) begin
                  idx_d   = '0;
                  state_d = (cnt_q.b != '0) ? StLoadB : StKick;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end

         StLoadB: begin
            if (bus_io.in_valid) begin
               b_we_d   = 1'b1;
               b_addr_d = b_base + 10'(idx_q);
               b_din_d  = bus_io.in_data;
               if (idx_q == cnt_q.b - 7'd1) begin
                  idx_d   = '0;
                  state_d = StKick;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end

         StKick: begin
            timer_d = '0;
            state_d = StWaitTp;
         end

         StWaitTp: begin
            if (bus_io.tp_done) begin
               idx_d   = '0;
               state_d = StRdIssue;
            end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end

         StRdIssue: begin
            state_d = StRdCap;
         end

         StRdCap: begin
            out_data_d = bus_io.sram_C_dout;
            out_last_d = (idx_q == cnt_q.c - 7'd1);
            state_d    = StRdOut;
         end

         StRdOut: begin
            if (bus_io.out_ready) begin
               if (out_last_q) begin
                  out_last_d = 1'b0;
                  state_d    = StIdle;
               end else begin
                  idx_d   = idx_q + 7'd1;
                  state_d = StRdIssue;
               end
            end
         end

         default: state_d = StIdle;
      endcase

      // Tile processor controls are loaded on entry to KICK and held through WAIT_TP.
      if (state_d == StKick && state_q != StKick) begin
         tp_start_d = 1'b1;
         tp_op_d    = op_d;
         tp_ti_d    = ti_d;
         tp_tj_d    = tj_d;
      end
      if (state_q == StWaitTp && state_d != StWaitTp) begin
         tp_op_d = '0;
         tp_ti_d = '0;
         tp_tj_d = '0;
      end
      // RD_ISSUE lasts one cycle, so the read address is registered on the way in.
      if (state_d == StRdIssue) begin
         c_addr_d = c_base + 10'(idx_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         timer_q    <= '0;
         op_q       <= '0;
         ti_q       <= '0;
         tj_q       <= '0;
         cnt_q      <= '0;
         a_we_q     <= 1'b0;
         b_we_q     <= 1'b0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         a_din_q    <= '0;
         b_din_q    <= '0;
         c_addr_q   <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         tp_start_q <= 1'b0;
         tp_op_q    <= '0;
         tp_ti_q    <= '0;
         tp_tj_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         op_q       <= op_d;
         ti_q       <= ti_d;
         tj_q       <= tj_d;
         cnt_q      <= cnt_d;
         a_we_q     <= a_we_d;
         b_we_q     <= b_we_d;
         a_addr_q   <= a_addr_d;
         b_addr_q   <= b_addr_d;
         a_din_q    <= a_din_d;
         b_din_q    <= b_din_d;
         c_addr_q   <= c_addr_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         tp_start_q <= tp_start_d;
         tp_op_q    <= tp_op_d;
         tp_ti_q    <= tp_ti_d;
         tp_tj_q    <= tp_tj_d;
         err_q      <= err_d;
      end
   end

   assign bus_io.cmd_ready   = cmd_ready;
   assign bus_io.in_ready    = (state_q == StLoadA) || (state_q == StLoadB);
   assign bus_io.out_valid   = (state_q == StRdOut);
   assign bus_io.out_data    = out_data_q;
   assign bus_io.out_last    = out_last_q;
   assign bus_io.sram_A_we   = a_we_q;
   assign bus_io.sram_B_we   = b_we_q;
   assign bus_io.sram_A_addr = a_addr_q;
   assign bus_io.sram_B_addr = b_addr_q;
   assign bus_io.sram_A_din  = a_din_q;
   assign bus_io.sram_B_din  = b_din_q;
   assign bus_io.sram_C_addr = c_addr_q;
   assign bus_io.tp_start    = tp_start_q;
   assign bus_io.tp_op       = tp_op_q;
   assign bus_io.tp_tile_i   = tp_ti_q;
   assign bus_io.tp_tile_j   = tp_tj_q;
   assign bus_io.busy        = (state_q != StIdle);
   assign bus_io.err         = err_q;

endmodule

// File: doc/tile_host_dma.md
TILE_HOST_DMA -- requirements
Module: tile_host_dma

Interface
REQ-001 Parameter TIMEOUT, default 4096: max cycles in WAIT_TP before abort.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake; cmd_op in 3, cmd_tile_i in 3, cmd_tile_j in 3.
REQ-005 in_valid/in_ready  in/out  1/1  operand byte stream, in_data in 8; A bytes first, then B bytes.
REQ-006 out_valid/out_ready  out/in  1/1  result byte stream; out_data out 8, out_last out 1.
REQ-007 sram_A_we, sram_B_we  out 1; sram_A_addr, sram_B_addr  out 10; sram_A_din, sram_B_din  out 8  operand SRAM write ports.
REQ-008 sram_C_addr  out 10; sram_C_dout  in 8  result SRAM read port, 1-cycle read latency.
REQ-009 tp_start  out 1; tp_op  out 3; tp_tile_i, tp_tile_j  out 3; tp_done  in 1  tile processor control.
REQ-010 busy  out 1  high in every state except IDLE; err  out 1  one-cycle abort/reject pulse.

Function
REQ-011 States SHALL be IDLE, LOAD_A, LOAD_B, KICK, WAIT_TP, RD_ISSUE, RD_CAP, RD_OUT.
REQ-012 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready latches op, tile_i, tile_j and selects the count table.
REQ-013 Count table (A, B, C bytes): MUL(0) 64,64,16; ADD(1)/SUB(2) 16,16,16; CONV(3) 36,9,16; DOT(4) 16,16,1.
REQ-014 Base addresses: A = tile_i*32; B = 0 for MUL, tile_j*16 for DOT, tile_i*32 otherwise; C = tile_i*32; all 10-bit, modulo 1024.
REQ-015 Op codes 5-7 SHALL be rejected: err pulses 1 cycle after accept, state stays IDLE, no SRAM or tp activity.
REQ-016 Accepted valid op SHALL go to LOAD_A (or LOAD_B if A count 0, never for defined ops).
REQ-017 in_ready SHALL be 1 only in LOAD_A/LOAD_B; each in handshake SHALL produce, next cycle, a one-cycle we on the active port with addr = base + index, din = in_data.
REQ-018 Index SHALL reset to 0 on LOAD_A->LOAD_B; LOAD_A exits after byte (A count-1), LOAD_B after byte (B count-1), to KICK.
REQ-019 in_valid low SHALL stall loading indefinitely without error; in bytes outside LOAD_* are not accepted.
REQ-020 KICK SHALL last exactly one cycle with tp_start=1; tp_op/tp_tile_i/tp_tile_j SHALL be held stable from KICK until leaving WAIT_TP.
REQ-021 tp_done SHALL be sampled only in WAIT_TP; tp_done high in KICK or any other state is ignored.
REQ-022 WAIT_TP->RD_ISSUE on tp_done; a cycle counter starting at 0 on entry SHALL abort to IDLE with err pulse when it reaches TIMEOUT without tp_done.
REQ-023 Readback per byte: RD_ISSUE drives sram_C_addr = C base + index; RD_CAP registers sram_C_dout into out_data; RD_OUT holds out_valid=1 with stable out_data until out_ready.
REQ-024 out_last SHALL be 1 with the final C byte only; after its handshake state returns to IDLE, otherwise index increments and state returns to RD_ISSUE.
REQ-025 Address arithmetic wraps modulo 1024; counters SHALL be wide enough for 64 without overflow.
REQ-026 All SRAM we, tp_start, err SHALL be registered, glitch-free, single-cycle pulses.

Reset
REQ-027 rst high SHALL immediately force IDLE; cmd_ready=0 while rst high, 1 after release.
REQ-028 During reset all outputs SHALL be 0: we, addr, din, out_valid, out_data, out_last, tp_start, tp_op, tp_tile_*, busy, err, in_ready.
REQ-029 Reset mid-load or mid-readback SHALL abandon the command; no partial write completes after rst asserts.
REQ-030 After release the block SHALL accept a new command with indices and counters at 0.

Verification
REQ-031 ADD tile_i=1: 32 bytes 0x01..0x20 -> A writes addr 32..47 data 0x01..0x10, B writes 32..47 data 0x11..0x20, one tp_start, tp_op=1.
REQ-032 DOT tile_i=2, tile_j=3, tp_done after 5 cycles, sram_C_dout=0x5A -> single out byte 0x5A with out_last=1, C addr 64.
REQ-033 MUL with out_ready toggled 1/0 each cycle and random in_valid gaps -> 128 writes in order (B at 0..63), 16 outputs in order, data stable while stalled.
REQ-034 cmd_op=6 -> err pulse 1 cycle, no we/tp_start, cmd_ready back to 1 next cycle.
REQ-035 TIMEOUT=16, tp_done never asserted -> err pulse 16 cycles after entering WAIT_TP, busy=0 after; tp_done pulse in KICK ignored.
REQ-036 rst asserted after 10 of 36 CONV A bytes -> all outputs 0 same cycle; next ADD command completes normally from address base.
